// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: bubble instruction, reset PC and the
// fetch state encoding used by if_stage.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  // sll $0,$0,0
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fetch_state_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with increment enable. Only the performance
// counters of if_stage use it, so it is built only with IF_STAGE_PERF_EN.
`ifdef IF_STAGE_PERF_EN
module sat_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  // Count up on inc, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/if_stage.sv
// MIPS instruction fetch stage: program counter, next-PC selection,
// IF/ID pipeline register and the BOOT/LOAD/RUN fetch state machine.
// Optional performance counters are enabled with IF_STAGE_PERF_EN.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        im_en,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
`ifdef IF_STAGE_PERF_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt,
`endif
  output logic        ifid_valid
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         redirect;
  logic [31:0]  redirect_pc;

  // Next-PC candidates; branch wins over jump when both resolve together.
  always_comb begin
    pc_plus4    = pc + 32'd4;
    redirect    = branch_taken | jump;
    redirect_pc = word_align(branch_taken ? branch_target : jump_target);
  end

  assign im_addr = pc;

  // Fetch FSM, PC register and IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      ifid_instr <= NOP;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state <= im_en ? LOAD : RUN;
        end
        LOAD: begin
          pc         <= RESET_PC;
          ifid_instr <= NOP;
          ifid_pc4   <= '0;
          ifid_valid <= 1'b0;
          if (!im_en) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (im_en) begin
            state      <= LOAD;
            pc         <= RESET_PC;
            ifid_instr <= NOP;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
          end else if (redirect) begin
            pc         <= redirect_pc;
            ifid_instr <= NOP;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
          end else if (stall) begin
            if (flush) begin
              ifid_instr <= NOP;
              ifid_pc4   <= '0;
              ifid_valid <= 1'b0;
            end
          end else if (flush) begin
            pc         <= pc_plus4;
            ifid_instr <= NOP;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
          end else begin
            pc         <= pc_plus4;
            ifid_instr <= im_data;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b1;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

`ifdef IF_STAGE_PERF_EN
  logic fetch_inc;
  logic bubble_inc;

  // Count real fetches into IF/ID and RUN cycles that lose a fetch slot.
  always_comb begin
    fetch_inc  = (state == RUN) && !im_en && !redirect && !stall && !flush;
    bubble_inc = (state == RUN) && (stall || flush || redirect);
  end

  sat_cnt #(.WIDTH(32)) u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fetch_inc),
    .cnt   (fetch_cnt)
  );

  sat_cnt #(.WIDTH(32)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble_inc),
    .cnt   (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a reference model pushes the expected
// post-edge outputs into a queue and each test pops and compares them.
module tb_if_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        im_en, stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] im_addr, im_data, ifid_instr, ifid_pc4;
  logic        ifid_valid;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  logic [31:0] mem [64];
  assign im_data = mem[im_addr[7:2]];

  always #5 clk = ~clk;

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .im_en         (im_en),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .im_addr       (im_addr),
    .im_data       (im_data),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
`ifdef IF_STAGE_PERF_EN
    .fetch_cnt     (fetch_cnt),
    .bubble_cnt    (bubble_cnt),
`endif
    .ifid_valid    (ifid_valid)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  fetch_state_t m_st;
  logic [31:0]  m_pc, m_instr, m_pc4, m_fc, m_bc;
  logic         m_valid;

  task automatic model_reset();
    m_st = BOOT; m_pc = 32'h0; m_instr = NOP_INSTR; m_pc4 = 32'h0;
    m_valid = 1'b0; m_fc = 32'h0; m_bc = 32'h0;
    exp_q.delete();
  endtask

  task automatic clear_inputs();
    im_en = 0; stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 32'h0; jump_target = 32'h0;
  endtask

  task automatic bubble();
    m_instr = NOP_INSTR; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  // Predict the effect of the coming edge, queue it, then advance one cycle.
  task automatic step();
    logic [31:0] p4;
    logic        redir;
    logic [31:0] tgt;
    exp_t        x;
    p4    = m_pc + 32'd4;
    redir = branch_taken | jump;
    tgt   = branch_taken ? branch_target : jump_target;
    if (m_st == RUN && (stall || flush || redir) && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
    case (m_st)
      BOOT: m_st = im_en ? LOAD : RUN;
      LOAD: begin
        m_pc = 32'h0; bubble();
        if (!im_en) m_st = RUN;
      end
      default: begin
        if (im_en) begin
          m_st = LOAD; m_pc = 32'h0; bubble();
        end else if (redir) begin
          m_pc = tgt & 32'hFFFF_FFFC; bubble();
        end else if (stall) begin
          if (flush) bubble();
        end else begin
          if (flush) bubble();
          else begin
            m_instr = mem[m_pc[7:2]]; m_pc4 = p4; m_valid = 1'b1;
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
          end
          m_pc = p4;
        end
      end
    endcase
    x.addr = m_pc; x.instr = m_instr; x.pc4 = m_pc4; x.valid = m_valid;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    #12;
    checks++;
    if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'h0, NOP_INSTR, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got addr=%h instr=%h pc4=%h v=%b exp all zero", im_addr, ifid_instr, ifid_pc4, ifid_valid);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (im_addr !== 32'h0) begin
      errors++;
      $display("FAIL boot_cycle0_addr got %h exp 00000000", im_addr);
    end
    repeat (2) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {e.addr, e.instr, e.pc4, e.valid}) begin
        errors++;
        $display("FAIL reset_release got addr=%h instr=%h pc4=%h v=%b exp addr=%h instr=%h pc4=%h v=%b",
                 im_addr, ifid_instr, ifid_pc4, ifid_valid, e.addr, e.instr, e.pc4, e.valid);
      end
    end
    checks++;
    if ({ifid_instr, ifid_pc4, ifid_valid} !== {32'h2008_0005, 32'h4, 1'b1}) begin
      errors++;
      $display("FAIL first_fetch got instr=%h pc4=%h v=%b exp 20080005 00000004 1", ifid_instr, ifid_pc4, ifid_valid);
    end
  endtask

  task automatic test_seq_stall();
    clear_inputs();
    repeat (3) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {e.addr, e.instr, e.pc4, e.valid}) begin
        errors++;
        $display("FAIL sequential got addr=%h instr=%h pc4=%h v=%b exp addr=%h instr=%h pc4=%h v=%b",
                 im_addr, ifid_instr, ifid_pc4, ifid_valid, e.addr, e.instr, e.pc4, e.valid);
      end
    end
    stall = 1;
    repeat (3) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {e.addr, e.instr, e.pc4, e.valid}) begin
        errors++;
        $display("FAIL stall_model got addr=%h instr=%h pc4=%h v=%b exp addr=%h instr=%h pc4=%h v=%b",
                 im_addr, ifid_instr, ifid_pc4, ifid_valid, e.addr, e.instr, e.pc4, e.valid);
      end
      checks++;
      if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'h10, mem[3], 32'h10, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold got addr=%h instr=%h pc4=%h v=%b exp addr=00000010 instr=%h pc4=00000010 v=1",
                 im_addr, ifid_instr, ifid_pc4, ifid_valid, mem[3]);
      end
    end
    stall = 0;
    step();
    e = exp_q.pop_front();
    checks++;
    if ({ifid_instr, ifid_pc4, ifid_valid} !== {mem[4], 32'h14, 1'b1} || e.pc4 !== 32'h14) begin
      errors++;
      $display("FAIL stall_resume got instr=%h pc4=%h v=%b exp instr=%h pc4=00000014 v=1", ifid_instr, ifid_pc4, ifid_valid, mem[4]);
    end
  endtask

  task automatic test_redirect();
    clear_inputs();
    stall = 1; branch_taken = 1; jump = 1;
    branch_target = 32'h40; jump_target = 32'h80;
    step();
    e = exp_q.pop_front();
    checks++;
    if ({im_addr, ifid_valid} !== {32'h40, 1'b0} || {e.addr, e.valid} !== {im_addr, ifid_valid}) begin
      errors++;
      $display("FAIL branch_over_jump got addr=%h v=%b exp addr=00000040 v=0", im_addr, ifid_valid);
    end
    clear_inputs();
    step();
    e = exp_q.pop_front();
    checks++;
    if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'h44, mem[16], 32'h44, 1'b1}) begin
      errors++;
      $display("FAIL branch_target_fetch got addr=%h instr=%h pc4=%h v=%b exp addr=00000044 instr=%h pc4=00000044 v=1",
               im_addr, ifid_instr, ifid_pc4, ifid_valid, mem[16]);
    end
  endtask

  task automatic test_load();
    clear_inputs();
    jump = 1; jump_target = 32'h20;
    step();
    e = exp_q.pop_front();
    clear_inputs();
    checks++;
    if (im_addr !== 32'h20) begin
      errors++;
      $display("FAIL load_setup got addr=%h exp 00000020", im_addr);
    end
    im_en = 1;
    repeat (5) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({im_addr, ifid_instr, ifid_valid} !== {32'h0, NOP_INSTR, 1'b0} || e.valid !== 1'b0) begin
        errors++;
        $display("FAIL load_park got addr=%h instr=%h v=%b exp addr=00000000 nop v=0", im_addr, ifid_instr, ifid_valid);
      end
    end
    im_en = 0;
    repeat (2) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {e.addr, e.instr, e.pc4, e.valid}) begin
        errors++;
        $display("FAIL load_exit got addr=%h instr=%h pc4=%h v=%b exp addr=%h instr=%h pc4=%h v=%b",
                 im_addr, ifid_instr, ifid_pc4, ifid_valid, e.addr, e.instr, e.pc4, e.valid);
      end
    end
    checks++;
    if ({ifid_instr, ifid_pc4, ifid_valid} !== {32'h2008_0005, 32'h4, 1'b1}) begin
      errors++;
      $display("FAIL load_first_fetch got instr=%h pc4=%h v=%b exp 20080005 00000004 1", ifid_instr, ifid_pc4, ifid_valid);
    end
  endtask

  task automatic test_align_wrap();
    clear_inputs();
    jump = 1; jump_target = 32'h0000_0083;
    step();
    e = exp_q.pop_front();
    checks++;
    if (im_addr !== 32'h80) begin
      errors++;
      $display("FAIL jump_align got addr=%h exp 00000080", im_addr);
    end
    jump_target = 32'hFFFF_FFFC;
    step();
    e = exp_q.pop_front();
    checks++;
    if (im_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_setup got addr=%h exp fffffffc", im_addr);
    end
    clear_inputs();
    step();
    e = exp_q.pop_front();
    checks++;
    if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'h0, mem[63], 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL pc_wrap got addr=%h instr=%h pc4=%h v=%b exp addr=00000000 instr=%h pc4=00000000 v=1",
               im_addr, ifid_instr, ifid_pc4, ifid_valid, mem[63]);
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      flush = (i < 2);
      stall = (i == 1);
      step();
      e = exp_q.pop_front();
      checks++;
      if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {e.addr, e.instr, e.pc4, e.valid}) begin
        errors++;
        $display("FAIL flush_%0d got addr=%h instr=%h pc4=%h v=%b exp addr=%h instr=%h pc4=%h v=%b",
                 i, im_addr, ifid_instr, ifid_pc4, ifid_valid, e.addr, e.instr, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      im_en         = ($urandom_range(0, 99) < 4);
      stall         = ($urandom_range(0, 99) < 20);
      flush         = ($urandom_range(0, 99) < 15);
      branch_taken  = ($urandom_range(0, 99) < 10);
      jump          = ($urandom_range(0, 99) < 10);
      branch_target = {24'h0, 8'($urandom())};
      jump_target   = {24'h0, 8'($urandom())};
      step();
      e = exp_q.pop_front();
      checks++;
      if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {e.addr, e.instr, e.pc4, e.valid}) begin
        errors++;
        $display("FAIL random_%0d got addr=%h instr=%h pc4=%h v=%b exp addr=%h instr=%h pc4=%h v=%b",
                 i, im_addr, ifid_instr, ifid_pc4, ifid_valid, e.addr, e.instr, e.pc4, e.valid);
      end
    end
    clear_inputs();
`ifdef IF_STAGE_PERF_EN
    checks++;
    if ({fetch_cnt, bubble_cnt} !== {m_fc, m_bc}) begin
      errors++;
      $display("FAIL random_counters got fetch=%0d bubble=%0d exp fetch=%0d bubble=%0d", fetch_cnt, bubble_cnt, m_fc, m_bc);
    end
`endif
  endtask

  task automatic test_perf_async_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    step();
    e = exp_q.pop_front();
    repeat (10) begin
      step();
      e = exp_q.pop_front();
    end
    stall = 1;
    repeat (3) begin
      step();
      e = exp_q.pop_front();
    end
    stall = 0;
    checks++;
    if ({im_addr, ifid_pc4, ifid_valid} !== {32'h28, 32'h28, 1'b1}) begin
      errors++;
      $display("FAIL perf_run got addr=%h pc4=%h v=%b exp addr=00000028 pc4=00000028 v=1", im_addr, ifid_pc4, ifid_valid);
    end
`ifdef IF_STAGE_PERF_EN
    checks++;
    if ({fetch_cnt, bubble_cnt} !== {32'd10, 32'd3}) begin
      errors++;
      $display("FAIL perf_counts got fetch=%0d bubble=%0d exp fetch=10 bubble=3", fetch_cnt, bubble_cnt);
    end
`endif
    rst_n = 0;
    #2;
    checks++;
    if ({im_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'h0, NOP_INSTR, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got addr=%h instr=%h pc4=%h v=%b exp all zero", im_addr, ifid_instr, ifid_pc4, ifid_valid);
    end
`ifdef IF_STAGE_PERF_EN
    checks++;
    if ({fetch_cnt, bubble_cnt} !== 64'h0) begin
      errors++;
      $display("FAIL async_reset_counters got fetch=%0d bubble=%0d exp 0 0", fetch_cnt, bubble_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    mem[0] = 32'h2008_0005;
    test_reset();
    test_seq_stall();
    test_redirect();
    test_load();
    test_align_wrap();
    test_flush();
    test_back_to_back();
    test_perf_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage of the MIPS pipeline. It owns the program counter, drives the instruction memory read address, and captures the returned instruction into the IF/ID pipeline register. It also performs next-PC selection (sequential, branch, jump), stall and flush handling, and a load/run state machine that parks fetch while instruction memory is being written. It sits directly upstream of instruction memory and directly feeds the decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset and after every memory load.
- NOP, 32'h0000_0000, bubble instruction (sll $0,$0,0) written into IF/ID on flush or when fetch is idle.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- im_en  in  1  instruction memory load in progress (same signal that enables memory writes).
- stall  in  1  hazard stall from decode: hold PC and IF/ID.
- flush  in  1  squash IF/ID contents (bubble).
- branch_taken  in  1  branch resolved taken.
- branch_target  in  32  branch destination byte address.
- jump  in  1  jump taken.
- jump_target  in  32  jump destination byte address.
- im_addr  out  32  read address to instruction memory, equal to the PC register.
- im_data  in  32  combinational read data from instruction memory for im_addr.
- ifid_instr  out  32  latched instruction.
- ifid_pc4  out  32  latched PC+4 of that instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.
- fetch_cnt, bubble_cnt  out  32 each  present only with IF_STAGE_PERF_EN.

## Operation
- State machine (fetch_state_t):
  - BOOT: entered on reset; lasts exactly one cycle. Next state is LOAD if im_en=1, else RUN.
  - LOAD: PC forced to RESET_PC; IF/ID = NOP, valid=0. Stays while im_en=1; moves to RUN when im_en=0.
  - RUN: normal fetch. If im_en rises, moves to LOAD; the PC is set to RESET_PC and IF/ID is bubbled on that same edge.
- Reset values: state=BOOT, pc=RESET_PC, ifid_instr=NOP, ifid_pc4=0, ifid_valid=0, counters=0.
- RUN priority per cycle, highest first:
  1. im_en
  2. redirect (branch_taken, then jump)
  3. stall
  4. sequential
- Redirect: PC←target with bits [1:0] forced to 00. IF/ID←NOP with valid=0, regardless of stall. When both branch_taken and jump are set, branch_target wins.
- flush without redirect: IF/ID←NOP with valid=0. PC holds if stall=1, otherwise PC←PC+4.
- stall only: PC and IF/ID hold their values.
- Sequential: IF/ID←{im_data, PC+4, valid=1}; PC←PC+4.
- Arithmetic: PC+4 is computed modulo 2^32. 32'hFFFF_FFFC wraps to 0. Memory index aliasing is the memory's concern.

## Timing
- im_addr is a direct register output; there is no combinational path from any input to im_addr.
- Instruction read from memory is combinational. The instruction at PC is visible on ifid_instr one cycle after PC appears on im_addr.
- Redirect asserted in cycle n:
  - im_addr = target in cycle n+1.
  - Target instruction valid in IF/ID in cycle n+2.
  - Exactly one bubble is inserted.
- Release from reset: cycle 0 is BOOT; first valid ifid output appears at cycle 2 (instruction at RESET_PC).
- im_en falling edge: first valid instruction appears two cycles after im_en is sampled low.
- rst_n asserted mid-operation immediately returns all state to reset values (asynchronous), including counters.

## Configuration
- IF_STAGE_PERF_EN defined:
  - fetch_cnt increments on every edge where ifid_valid is written to 1.
  - bubble_cnt increments on every RUN-state edge with stall, flush, or redirect active.
  - Both counters saturate at 32'hFFFF_FFFF.
- IF_STAGE_PERF_EN undefined: the counter ports and logic do not exist; the functional behaviour is otherwise identical.

## Structure
- Shared package mips_pkg holds:
  - NOP_INSTR constant.
  - RESET_PC_DEFAULT constant.
  - fetch_state_t enum {BOOT, LOAD, RUN}.
- One sub-module: sat_cnt, a 32-bit saturating counter with async active-low reset and an increment enable. It is instantiated twice, under IF_STAGE_PERF_EN only.

## Test plan
- Reset release with im_en=0 and memory word0=32'h2008_0005 → im_addr=0 at cycles 0–1; cycle 2 gives ifid_instr=32'h2008_0005, ifid_pc4=4, valid=1.
- Four-cycle sequential run, then stall held for 3 cycles → im_addr frozen at 32'h10 and IF/ID unchanged for 3 cycles; fetch resumes at 32'h10.
- branch_taken=1 and jump=1 in the same cycle, with branch_target=32'h40 and jump_target=32'h80 (stall=1 as well) → next im_addr=32'h40, one bubble (valid=0), then instruction at 32'h40 with pc4=32'h44.
- im_en pulsed for 5 cycles mid-run at PC=32'h20 → IF/ID bubbles and PC=RESET_PC throughout; valid fetch of word0 occurs 2 cycles after im_en falls.
- jump_target=32'h0000_0083, and separately PC preset to 32'hFFFF_FFFC → im_addr=32'h80 in the first case; PC wraps to 0 in the second.
- With IF_STAGE_PERF_EN: 10 valid fetches plus 3 stall cycles give fetch_cnt=10 and bubble_cnt=3; asserting rst_n low mid-run clears both to 0 asynchronously.
